// File: rtl/bus_select_decoder.sv
// Bus transfer sequencer: turns a (source, destination) request into one-hot
// out/in enables over a DRIVE then LATCH phase and counts completed transfers.
module bus_select_decoder #(
   parameter int NUM_SRC   = 24,
   parameter int NUM_DST   = 24,
   parameter int IDLE_CODE = 31,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [5:0]         src_code,
   input  logic [5:0]         dst_code,
   output logic [NUM_SRC-1:0] out_en,
   output logic [NUM_DST-1:0] in_en,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   xfer_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [5:0]         src_r;
   logic [5:0]         dst_r;
   logic [NUM_SRC-1:0] out_en_r;
   logic [NUM_DST-1:0] in_en_r;
   logic               done_r;
   logic               err_r;
   logic               req_ready_r;
   logic [CNT_W-1:0]   xfer_count_r;

   logic [NUM_SRC-1:0] out_en_s;
   logic [NUM_DST-1:0] in_en_s;
   logic               done_s;
   logic               err_s;
   logic               load_s;
   logic [CNT_W-1:0]   count_s;

   // IDLE_CODE is a legal "nothing on this side" request, not an error
   function automatic logic src_ok(input logic [5:0] code);
      return (int'(code) < NUM_SRC) || (int'(code) == IDLE_CODE);
   endfunction

   function automatic logic dst_ok(input logic [5:0] code);
      return (int'(code) < NUM_DST) || (int'(code) == IDLE_CODE);
   endfunction

   function automatic logic [NUM_SRC-1:0] src_onehot(input logic [5:0] code);
      logic [NUM_SRC-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((int'(code) == i) && (int'(code) != IDLE_CODE)) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   function automatic logic [NUM_DST-1:0] dst_onehot(input logic [5:0] code);
      logic [NUM_DST-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_DST; i++) begin
         if ((int'(code) == i) && (int'(code) != IDLE_CODE)) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   // next state plus next value of every registered output
   always_comb begin
      next_state_s = state_r;
      out_en_s     = '0;
      in_en_s      = '0;
      done_s       = 1'b0;
      err_s        = 1'b0;
      load_s       = 1'b0;
      count_s      = xfer_count_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && req_ready_r) begin
               if (src_ok(src_code) && dst_ok(dst_code)) begin
                  load_s       = 1'b1;
                  next_state_s = ST_DRIVE;
                  out_en_s     = src_onehot(src_code);
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            next_state_s = ST_LATCH;
            out_en_s     = src_onehot(src_r);
            in_en_s      = dst_onehot(dst_r);
         end
         ST_LATCH: begin
            next_state_s = ST_IDLE;
            done_s       = 1'b1;
            if (xfer_count_r == '1) begin
               count_s = xfer_count_r;
            end else begin
               count_s = xfer_count_r + CNT_W'(1);
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // state and output registers; clr drops every enable at the same edge
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r      <= ST_IDLE;
         src_r        <= 6'd0;
         dst_r        <= 6'd0;
         out_en_r     <= '0;
         in_en_r      <= '0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         req_ready_r  <= 1'b0;
         xfer_count_r <= '0;
      end else begin
         state_r      <= next_state_s;
         out_en_r     <= out_en_s;
         in_en_r      <= in_en_s;
         done_r       <= done_s;
         err_r        <= err_s;
         req_ready_r  <= (next_state_s == ST_IDLE);
         xfer_count_r <= count_s;
         if (load_s) begin
            src_r <= src_code;
            dst_r <= dst_code;
         end else begin
            src_r <= src_r;
            dst_r <= dst_r;
         end
      end
   end

   assign req_ready  = req_ready_r;
   assign out_en     = out_en_r;
   assign in_en      = in_en_r;
   assign done       = done_r;
   assign err        = err_r;
   assign xfer_count = xfer_count_r;

endmodule
